alu_multibyte_seq: RTL and testbench

- Sequencer that runs multi-byte add/subtract on the shared 8-bit carry-lookahead adder, one byte per cycle, least-significant byte first.
- Latches full-width operands on a valid/ready request and drives the adder's a/b/cin each cycle. It chains the inter-byte carry and returns the result plus C/V/N/Z flags on a valid/ready response.
- Sits between the instruction sequencer and the adder instance.

---
 rtl/alu_multibyte_seq.sv | 144 ++++++++++++++
 tb/tb_alu_multibyte_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multibyte_seq.sv
// Multi-byte add/subtract sequencer driving a shared 8-bit adder, LSB first, with C/V/N/Z flags.
// Latency: accept edge to rsp_valid = NBYTES+1 edges; one op per NBYTES+2 cycles.
// Backpressure: req_ready only in IDLE; response held stable while rsp_ready=0.
// Optional: define ALU_SEQ_CARRYIN_EN to add req_cin (ADC/SBC carry/borrow in).
module alu_multibyte_seq #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
`ifdef ALU_SEQ_CARRYIN_EN
  input  logic                  req_cin,
`endif
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_result,
  output logic                  rsp_c,
  output logic                  rsp_v,
  output logic                  rsp_n,
  output logic                  rsp_z,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_out,
  input  logic                  add_cout,
  input  logic                  add_overflow
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [IDXW-1:0] idx_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    result_q;
  logic            op_q;
  logic            carry_q;
  logic            zacc_q;
  logic            v_q;
  logic            n_q;

  // Initial inter-byte carry: subtract is a + ~b + 1, so borrow-in inverts the carry-in.
  logic            start_carry_d;
`ifdef ALU_SEQ_CARRYIN_EN
  assign start_carry_d = req_op ? ~req_cin : req_cin;
`else
  assign start_carry_d = req_op;
`endif

  logic       run;
  logic       done;
  logic [7:0] byte_a;
  logic [7:0] byte_e;

  assign run  = (state_q == RUN);
  assign done = (state_q == DONE);

  // Current byte of each operand; for subtract the effective b byte is inverted.
  always_comb begin
    byte_a = a_q[idx_q*8 +: 8];
    byte_e = op_q ? ~b_q[idx_q*8 +: 8] : b_q[idx_q*8 +: 8];
  end

  // Adder drive: the adder inverts b when cin=1, so pre-invert to make it compute a+e+c.
  always_comb begin
    add_a   = 8'h00;
    add_b   = 8'h00;
    add_cin = 1'b0;
    if (run) begin
      add_a   = byte_a;
      add_b   = carry_q ? ~byte_e : byte_e;
      add_cin = carry_q;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = done;
  assign rsp_result = result_q;
  assign rsp_c      = done & (op_q ^ carry_q);
  assign rsp_v      = done & v_q;
  assign rsp_n      = done & n_q;
  assign rsp_z      = done & zacc_q;

  // Sequencer FSM: accept, walk bytes LSB first chaining the carry, hold response until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      op_q     <= 1'b0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b1;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            a_q     <= req_a;
            b_q     <= req_b;
            op_q    <= req_op;
            carry_q <= start_carry_d;
            idx_q   <= '0;
            zacc_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          result_q[idx_q*8 +: 8] <= add_out;
          carry_q <= add_cout;
          zacc_q  <= zacc_q & (add_out == 8'h00);
          if (idx_q == LAST_IDX) begin
            v_q     <= add_overflow;
            n_q     <= add_out[7];
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Bench for alu_multibyte_seq (NBYTES=2) with a behavioural 8-bit adder attached.
// Directed vectors, backpressure, mid-run reset and randomized ops against a full-width model.
// Define ALU_SEQ_CARRYIN_EN to also exercise the carry-in port.
module tb_alu_multibyte_seq;

  localparam int NBYTES = 2;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_cin;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_c, rsp_v, rsp_n, rsp_z;
  logic [7:0]   add_a, add_b, add_out;
  logic         add_cin, add_cout, add_overflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] addb_q[$];
  logic       addcin_q[$];

  always #5 clk = ~clk;

  alu_multibyte_seq #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
`ifdef ALU_SEQ_CARRYIN_EN
    .req_cin(req_cin),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_c(rsp_c), .rsp_v(rsp_v), .rsp_n(rsp_n), .rsp_z(rsp_z),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_out(add_out), .add_cout(add_cout), .add_overflow(add_overflow)
  );

  // Shared adder: cin=1 inverts b internally, then computes a + b' + cin.
  logic [7:0] adder_eff;
  logic [8:0] adder_sum;
  always_comb begin
    adder_eff    = add_cin ? ~add_b : add_b;
    adder_sum    = {1'b0, add_a} + {1'b0, adder_eff} + {8'h00, add_cin};
    add_out      = adder_sum[7:0];
    add_cout     = adder_sum[8];
    add_overflow = (add_a[7] == adder_eff[7]) && (adder_sum[7] != add_a[7]);
  end

  // Full-width reference: flags as {c, v, n, z}; c is carry for add, borrow for sub.
  function automatic void model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, output logic [W-1:0] r, output logic [3:0] f);
    logic [W:0] wide;
    logic c, v;
    if (!op) begin
      wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      r = wide[W-1:0];
      c = wide[W];
      v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r = a - b - {{(W-1){1'b0}}, cin};
      c = ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, cin}));
      v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end
    f = {c, v, r[W-1], (r == '0)};
  endfunction

  // Issue one request and wait (bounded) for the response; leaves it pending.
  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, output logic [W-1:0] r, output logic [3:0] f,
                        output int lat, output bit ok);
    int n;
    ok = 1;
    addb_q.delete();
    addcin_q.delete();
    req_op = op; req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) ok = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      addb_q.push_back(add_b);
      addcin_q.push_back(add_cin);
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) ok = 0;
    r = rsp_result;
    f = {rsp_c, rsp_v, rsp_n, rsp_z};
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 1'b0; req_a = '0; req_b = '0; req_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (rsp_result !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", rsp_result); end
    total++; if ({rsp_c, rsp_v, rsp_n, rsp_z} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {rsp_c, rsp_v, rsp_n, rsp_z}); end
    total++; if ({add_a, add_b, add_cin} !== 17'h0) begin bad++; $display("FAIL reset_adder got=%h/%h/%b want=0", add_a, add_b, add_cin); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Directed vectors: {op, a, b, expected result, expected {c,v,n,z}}.
  task automatic test_addsub();
    logic [W-1:0] ta[6], tb[6], tr[6];
    logic         top[6];
    logic [3:0]   tf[6];
    logic [W-1:0] r;
    logic [3:0]   f;
    int lat;
    bit ok;
    top[0]=0; ta[0]=16'h00FF; tb[0]=16'h0001; tr[0]=16'h0100; tf[0]=4'b0000;
    top[1]=0; ta[1]=16'h7FFF; tb[1]=16'h0001; tr[1]=16'h8000; tf[1]=4'b0110;
    top[2]=0; ta[2]=16'hFFFF; tb[2]=16'h0001; tr[2]=16'h0000; tf[2]=4'b1001;
    top[3]=1; ta[3]=16'h0000; tb[3]=16'h0001; tr[3]=16'hFFFF; tf[3]=4'b1010;
    top[4]=1; ta[4]=16'h1234; tb[4]=16'h1234; tr[4]=16'h0000; tf[4]=4'b0001;
    top[5]=1; ta[5]=16'h8000; tb[5]=16'h0001; tr[5]=16'h7FFF; tf[5]=4'b0100;
    for (int i = 0; i < 6; i++) begin
      run_op(top[i], ta[i], tb[i], 1'b0, r, f, lat, ok);
      total++; if (!ok) begin bad++; $display("FAIL dir%0d_handshake timeout", i); end
      total++; if (r !== tr[i]) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, r, tr[i]); end
      total++; if (f !== tf[i]) begin bad++; $display("FAIL dir%0d_flags got=%b want=%b", i, f, tf[i]); end
      total++; if (lat !== NBYTES + 1) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, NBYTES + 1); end
      if (i == 0) begin
        // Byte 1 of 0x00FF+0x0001: carry in from byte 0, effective b=0x00 pre-inverted to 0xFF.
        total++; if (addcin_q.size() != NBYTES || addcin_q[1] !== 1'b1) begin bad++; $display("FAIL dir0_byte1_cin want=1 size=%0d", addcin_q.size()); end
        total++; if (addb_q.size() != NBYTES || addb_q[1] !== 8'hFF) begin bad++; $display("FAIL dir0_byte1_addb want=ff size=%0d", addb_q.size()); end
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r, er;
    logic [3:0]   f, ef;
    int lat;
    bit ok;
    model(1'b0, 16'h1234, 16'h4321, 1'b0, er, ef);
    run_op(1'b0, 16'h1234, 16'h4321, 1'b0, r, f, lat, ok);
    total++; if (!ok || r !== er) begin bad++; $display("FAIL bp_first got=%h want=%h ok=%0d", r, er, ok); end
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin req_valid = 1'b1; req_a = 16'hAAAA; req_b = 16'h5555; req_op = 1'b1; end
      else req_valid = 1'b0;
      @(posedge clk); #1;
      total++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL bp_hold%0d valid=%b ready=%b want 1/0", k, rsp_valid, req_ready); end
      total++; if (rsp_result !== er || {rsp_c, rsp_v, rsp_n, rsp_z} !== ef) begin bad++; $display("FAIL bp_stable%0d got=%h/%b want=%h/%b", k, rsp_result, {rsp_c, rsp_v, rsp_n, rsp_z}, er, ef); end
    end
    req_valid = 1'b0;
    consume();
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL bp_release valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] r;
    logic [3:0]   f;
    int lat;
    bit ok;
    req_op = 1'b0; req_a = 16'h0101; req_b = 16'h0101; req_cin = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if (add_a !== 8'h01) begin bad++; $display("FAIL rst_run_byte0 add_a got=%h want=01", add_a); end
    rst_n = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_async_hs ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
    total++; if (rsp_result !== '0 || {rsp_c, rsp_v, rsp_n, rsp_z} !== 4'b0000) begin bad++; $display("FAIL rst_async_rsp got=%h/%b want=0", rsp_result, {rsp_c, rsp_v, rsp_n, rsp_z}); end
    total++; if ({add_a, add_b, add_cin} !== 17'h0) begin bad++; $display("FAIL rst_async_adder got=%h/%h/%b want=0", add_a, add_b, add_cin); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_no_valid%0d got=%b want=0", k, rsp_valid); end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b0, 16'h0002, 16'h0003, 1'b0, r, f, lat, ok);
    total++; if (!ok || r !== 16'h0005 || f !== 4'b0000) begin bad++; $display("FAIL rst_after got=%h/%b want=0005/0000 ok=%0d", r, f, ok); end
    consume();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r, er;
    logic [3:0]   f, ef;
    logic         op, cin;
    int lat;
    bit ok;
    for (int i = 0; i < 60; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = W'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
      if ($urandom_range(0, 5) == 0) a = {1'b1, {(W-1){1'b0}}};
      if ($urandom_range(0, 5) == 0) b = {1'b0, {(W-1){1'b1}}};
`ifdef ALU_SEQ_CARRYIN_EN
      cin = 1'($urandom_range(0, 1));
`else
      cin = 1'b0;
`endif
      model(op, a, b, cin, er, ef);
      run_op(op, a, b, cin, r, f, lat, ok);
      total++; if (!ok || r !== er || f !== ef || lat !== NBYTES + 1) begin
        bad++;
        $display("FAIL rand%0d op=%b a=%h b=%h cin=%b got=%h/%b lat=%0d want=%h/%b lat=%0d", i, op, a, b, cin, r, f, lat, er, ef, NBYTES + 1);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      consume();
    end
  endtask

`ifdef ALU_SEQ_CARRYIN_EN
  task automatic test_carryin();
    logic [W-1:0] r;
    logic [3:0]   f;
    int lat;
    bit ok;
    run_op(1'b0, 16'hFFFF, 16'h0000, 1'b1, r, f, lat, ok);
    total++; if (!ok || r !== 16'h0000 || f !== 4'b1001) begin bad++; $display("FAIL adc got=%h/%b want=0000/1001", r, f); end
    consume();
    run_op(1'b1, 16'h0005, 16'h0003, 1'b1, r, f, lat, ok);
    total++; if (!ok || r !== 16'h0001 || f !== 4'b0000) begin bad++; $display("FAIL sbc got=%h/%b want=0001/0000", r, f); end
    consume();
  endtask
`endif

  initial begin
    test_reset();
    test_addsub();
    test_backpressure();
    test_reset_mid_run();
`ifdef ALU_SEQ_CARRYIN_EN
    test_carryin();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
